icache_controller: RTL

Direct-mapped instruction cache placed between the CPU fetch stage and the block-read instruction memory. It serves 32-bit instruction fetches on hits in the same cycle. On a miss it stalls the CPU, runs the memory's read/busywait block-read handshake to fetch a 128-bit line, installs the line and resumes.

---
 rtl/icache_pkg.sv | 20 ++
 rtl/icache_line_store.sv | 51 +++++
 rtl/icache_controller.sv | 105 ++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared constants and state encoding for the direct-mapped instruction cache.
package icache_pkg;

  localparam int unsigned ADDR_BITS     = 32;
  localparam int unsigned WORD_BITS     = 32;
  localparam int unsigned LINE_BITS     = 128;
  localparam int unsigned BYTE_OFF_BITS = 2;
  localparam int unsigned OFFSET_BITS   = 2;
  localparam int unsigned BLOCK_LSB     = BYTE_OFF_BITS + OFFSET_BITS;
  localparam int unsigned BLOCK_BITS    = ADDR_BITS - BLOCK_LSB;
  localparam int unsigned INDEX_BITS    = 3;
  localparam int unsigned TAG_BITS      = BLOCK_BITS - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    FILL     = 2'd2
  } icache_state_t;

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays of the instruction cache.
//   clock, reset          : clock, async active-low reset (clears valid bits only)
//   rd_index              : asynchronous read index
//   rd_valid/rd_tag/rd_line : contents of the indexed line
//   wr_en/wr_index/wr_tag/wr_line : single synchronous write port (line install)
module icache_line_store
  import icache_pkg::*;
#(
  parameter int unsigned LINES  = 8,
  parameter int unsigned IDX_W  = INDEX_BITS,
  parameter int unsigned TAG_W  = TAG_BITS,
  parameter int unsigned LINE_W = LINE_BITS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rd_index,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_line
);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  // Valid bits are the only state that reset must clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data are qualified by valid, so they need no reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_line  = data_q[rd_index];

endmodule

// File: rtl/icache_controller.sv
// Direct-mapped instruction cache between CPU fetch and a block-read memory.
// Hits are served combinationally; a miss stalls the CPU, performs one
// read/busywait block read and installs the 128-bit line.
//   clock, reset           : clock, async active-low reset
//   read, address          : CPU fetch request and byte address
//   instruction, busywait  : fetched word (0 unless hit), CPU stall
//   mem_read, mem_address  : registered block-read request and block address
//   mem_readdata, mem_busywait : memory line data and busy flag
module icache_controller
  import icache_pkg::*;
#(
  parameter int unsigned LINES     = 8,
  parameter int unsigned LINE_BITS = 128
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  read,
  input  logic [ADDR_BITS-1:0]  address,
  output logic [WORD_BITS-1:0]  instruction,
  output logic                  busywait,
  output logic                  mem_read,
  output logic [BLOCK_BITS-1:0] mem_address,
  input  logic [LINE_BITS-1:0]  mem_readdata,
  input  logic                  mem_busywait
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = BLOCK_BITS - IDX_W;

  icache_state_t state, state_nxt;
  logic [BLOCK_BITS-1:0] miss_addr;

  logic [OFFSET_BITS-1:0] addr_offset;
  logic [IDX_W-1:0]       addr_index;
  logic [TAG_W-1:0]       addr_tag;
  logic                   rd_valid;
  logic [TAG_W-1:0]       rd_tag;
  logic [LINE_BITS-1:0]   rd_line;
  logic                   hit_c;
  logic                   miss_c;
  logic                   fill_c;
  logic                   unused_byte_bits;

  assign addr_offset      = address[BYTE_OFF_BITS +: OFFSET_BITS];
  assign addr_index       = address[BLOCK_LSB +: IDX_W];
  assign addr_tag         = address[ADDR_BITS-1 -: TAG_W];
  assign unused_byte_bits = ^address[BYTE_OFF_BITS-1:0];

  assign fill_c = (state == FILL);

  icache_line_store #(
    .LINES  (LINES),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .LINE_W (LINE_BITS)
  ) u_store (
    .clock    (clock),
    .reset    (reset),
    .rd_index (addr_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .wr_en    (fill_c),
    .wr_index (miss_addr[IDX_W-1:0]),
    .wr_tag   (miss_addr[BLOCK_BITS-1 -: TAG_W]),
    .wr_line  (mem_readdata)
  );

  // Hit detection and word select are purely combinational.
  assign hit_c  = read && rd_valid && (rd_tag == addr_tag);
  assign miss_c = read && !hit_c;

  assign instruction = hit_c ? rd_line[32'(addr_offset) * WORD_BITS +: WORD_BITS]
                             : '0;
  assign busywait    = (state == IDLE) ? miss_c : 1'b1;
  assign mem_address = miss_addr;

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (miss_c)        state_nxt = MEM_READ;
      MEM_READ: if (!mem_busywait) state_nxt = FILL;
      FILL:                        state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // State, miss address and registered memory request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      miss_addr <= '0;
      mem_read  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && miss_c) begin
        miss_addr <= address[ADDR_BITS-1:BLOCK_LSB];
      end
      // High for exactly the cycles spent in MEM_READ, so no gaps or repeats.
      mem_read <= (state_nxt == MEM_READ);
    end
  end

endmodule
